// File: rtl/handshake_pkg.sv
// Shared definitions for the valid-path register slice.
//   DEFAULT_DATA_W : default payload width
//   clog2_plus1(n) : bits needed to hold the values 0..n (occupancy width)
package handshake_pkg;

  localparam int DEFAULT_DATA_W = 32;

  // Smallest w >= 1 with 2**w > n, so a counter of width w reaches n.
  function automatic int clog2_plus1(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w++;
    return w;
  endfunction

endpackage

// File: rtl/handshake_pipe_valid_stage.sv
// One forward register stage of the valid-path slice.
//   in_valid/in_data   : beat offered from upstream
//   in_ready           : this stage can take a beat (empty, or downstream ready)
//   out_valid/out_data : registered beat held by this stage
//   out_ready          : downstream accepts this stage's beat
module handshake_pipe_valid_stage
  import handshake_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              v_q, v_d;
  logic [DATA_W-1:0] d_q, d_d;

  // An empty stage accepts regardless of downstream (bubble collapse).
  // Data is only loaded with a real beat so the port holds its last value.
  always_comb begin
    in_ready = ~v_q | out_ready;
    v_d      = v_q;
    d_d      = d_q;
    if (in_ready) begin
      v_d = in_valid;
      if (in_valid) d_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign out_valid = v_q;
  assign out_data  = d_q;

endmodule

// File: rtl/handshake_pipe_valid_patting.sv
// Forward-path (valid/data) register slice: STAGES stages in a chain, so
// slave_valid/slave_data come straight from flops; ready ripples back
// combinationally and collapses bubbles to keep full throughput.
//   clk, rst                 : clock, async active-high reset
//   master_valid/data/ready  : upstream handshake
//   slave_valid/data/ready   : downstream handshake
//   occupancy                : number of stages holding a beat (registered)
module handshake_pipe_valid_patting
  import handshake_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             master_valid,
  input  logic [DATA_W-1:0]                master_data,
  output logic                             master_ready,
  output logic                             slave_valid,
  output logic [DATA_W-1:0]                slave_data,
  input  logic                             slave_ready,
  output logic [clog2_plus1(STAGES)-1:0]   occupancy
);

  localparam int OCC_W = clog2_plus1(STAGES);

  // Index 0 is the master side, index STAGES the slave side.
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][DATA_W-1:0] data_pipe;

  assign vld_pipe[0]  = master_valid;
  assign data_pipe[0] = master_data;

  // Ready is kept as a per-block signal rather than one vector so the
  // combinational ripple is not seen as a self-loop on a single variable.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic rdy;
    logic nxt_rdy;

    if (g == STAGES - 1) begin : g_last
      assign nxt_rdy = slave_ready;
    end else begin : g_mid
      assign nxt_rdy = g_stage[g+1].rdy;
    end

    handshake_pipe_valid_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld_pipe[g]),
      .in_data   (data_pipe[g]),
      .in_ready  (rdy),
      .out_valid (vld_pipe[g+1]),
      .out_data  (data_pipe[g+1]),
      .out_ready (nxt_rdy)
    );
  end

  // Depends only on slave_ready and the stage valid flops.
  assign master_ready = g_stage[0].rdy;
  assign slave_valid  = vld_pipe[STAGES];
  assign slave_data   = data_pipe[STAGES];

  // Occupancy tracks popcount of stage valids via transfer events.
  logic             in_xfer, out_xfer;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign in_xfer  = master_valid & master_ready;
  assign out_xfer = slave_valid & slave_ready;

  always_comb begin
    occ_d = occ_q;
    if (in_xfer && !out_xfer)      occ_d = occ_q + OCC_W'(1);
    else if (!in_xfer && out_xfer) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule
